// File: rtl/fetch_realign_buffer.sv
// Fetch realignment buffer: turns a halfword-aligned PC into one aligned
// RV32I or RVC instruction, backed by a single-entry word buffer.
module fetch_realign_buffer #(
    parameter bit RDATA_BIG_ENDIAN = 1'b1,
    parameter int ADDR_W           = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       pc,
    output logic              ready,
    output logic              compressed,
    output logic [31:0]       inst,
    input  logic              ICACHE_stall,
    output logic              ICACHE_ren,
    output logic              ICACHE_wen,
    output logic [ADDR_W-1:0] ICACHE_addr,
    input  logic [31:0]       ICACHE_rdata,
    output logic [31:0]       ICACHE_wdata
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    logic              buf_valid;
    logic [ADDR_W-1:0] buf_tag;
    logic [31:0]       buf_data;
    logic [ADDR_W-1:0] req_addr_r;

    logic [ADDR_W-1:0] w_addr, n_addr;
    logic [31:0]       rdata_n;
    logic              hit_w, hit_n;
    logic              buf_straddle;
    logic              req_ren;
    logic [ADDR_W-1:0] req_addr;
    logic              comp;
    logic              fwd_w, fwd_n;
    logic              avail_w, avail_n;
    logic [31:0]       word_w, word_n;
    logic [15:0]       lo_w, hi_w;
    logic              straddle;
    logic              rdy;
    logic              is_rvc;
    logic [31:0]       inst_c;
    logic              unused_pc0;

    assign unused_pc0 = pc[0];

    assign w_addr = pc[ADDR_W+1:2];
    assign n_addr = w_addr + ADDR_W'(1);

    // Bring the cache word into little-endian byte order once, at the port.
    generate
        if (RDATA_BIG_ENDIAN) begin : g_swap
            assign rdata_n = {ICACHE_rdata[7:0],   ICACHE_rdata[15:8],
                              ICACHE_rdata[23:16], ICACHE_rdata[31:24]};
        end else begin : g_noswap
            assign rdata_n = ICACHE_rdata;
        end
    endgenerate

    assign hit_w = buf_valid && (buf_tag == w_addr);
    assign hit_n = buf_valid && (buf_tag == n_addr);

    // Request selection only looks at the buffer, never at forwarded data,
    // which keeps ren/addr free of a loop through ICACHE_rdata.
    assign buf_straddle = pc[1] && (buf_data[17:16] == 2'b11);

    always_comb begin
        req_ren  = 1'b0;
        req_addr = w_addr;
        state_d  = state_q;
        if (state_q == S_WAIT) begin
            req_ren  = 1'b1;
            req_addr = req_addr_r;
            if (!ICACHE_stall) begin
                state_d = S_IDLE;
            end
        end else if (!hit_w) begin
            req_ren  = 1'b1;
            req_addr = w_addr;
        end else if (buf_straddle && !hit_n) begin
            req_ren  = 1'b1;
            req_addr = n_addr;
        end
        if (state_q == S_IDLE && req_ren && ICACHE_stall) begin
            state_d = S_WAIT;
        end
        if (!rst_n) begin
            req_ren = 1'b0;
            state_d = S_IDLE;
        end
    end

    assign comp  = req_ren && !ICACHE_stall;
    assign fwd_w = comp && (req_addr == w_addr);
    assign fwd_n = comp && (req_addr == n_addr);

    assign avail_w = hit_w || fwd_w;
    assign avail_n = hit_n || fwd_n;
    assign word_w  = fwd_w ? rdata_n : buf_data;
    assign word_n  = fwd_n ? rdata_n : buf_data;

    assign lo_w     = word_w[15:0];
    assign hi_w     = word_w[31:16];
    assign straddle = pc[1] && (hi_w[1:0] == 2'b11);

    assign rdy = rst_n && avail_w && (!straddle || avail_n);

    always_comb begin
        is_rvc = 1'b0;
        inst_c = 32'h0;
        if (!pc[1]) begin
            is_rvc = (lo_w[1:0] != 2'b11);
            inst_c = is_rvc ? {16'h0, lo_w} : word_w;
        end else begin
            is_rvc = (hi_w[1:0] != 2'b11);
            inst_c = is_rvc ? {16'h0, hi_w} : {word_n[15:0], hi_w};
        end
    end

    assign ready      = rdy;
    assign compressed = rdy && is_rvc;
    assign inst       = rdy ? inst_c : 32'h0;

    assign ICACHE_ren   = req_ren;
    assign ICACHE_addr  = req_ren ? req_addr : '0;
    assign ICACHE_wen   = 1'b0;
    assign ICACHE_wdata = 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            req_addr_r <= '0;
            buf_valid  <= 1'b0;
            buf_tag    <= '0;
            buf_data   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_ren && ICACHE_stall) begin
                req_addr_r <= req_addr;
            end
            if (comp) begin
                buf_valid <= 1'b1;
                buf_tag   <= req_addr;
                buf_data  <= rdata_n;
            end
        end
    end

endmodule
